parity_frame_tx: RTL and testbench
==================================

PARITY_FRAME_TX -- requirements
Module: parity_frame_tx

Interface
REQ-001 Parameter DATA_W, default 8, payload width in bits; legal range 1..16.
REQ-002 Parameter CLKS_PER_BIT, default 4, clock cycles each serial bit is held; legal range 1..65535.
REQ-003 Port clk  input  1  single clock, rising-edge active.
REQ-004 Port rst  input  1  reset, asynchronous, active-high.
REQ-005 Port din  input  DATA_W  payload word to transmit.
REQ-006 Port din_valid  input  1  requester has a word on din.
REQ-007 Port din_ready  output  1  block can accept a word this cycle.
REQ-008 Port tx  output  1  serial line, idle high.
REQ-009 Port busy  output  1  frame in progress.
REQ-010 Port par_out  output  1  even-parity bit of the most recently accepted word.

Function
REQ-011 States SHALL be IDLE, START, DATA, PARITY and STOP, in a registered FSM.
REQ-012 din_ready SHALL be a combinational decode of state==IDLE, with no dependency on din_valid.
REQ-013 Accept SHALL occur at a rising edge where din_valid=1 and din_ready=1: latch din into the shift register, compute the parity bit, and go IDLE->START.
REQ-014 The parity bit SHALL be the XOR reduction of the accepted word, so data bits plus parity contain an even number of ones; it is registered into par_out at accept.
REQ-015 The registered tx value SHALL be 1 in IDLE, 0 in START, the current data bit in DATA (LSB first), par_out in PARITY, and 1 in STOP.
REQ-016 Each of START, PARITY and STOP SHALL last exactly CLKS_PER_BIT cycles, and DATA SHALL last DATA_W*CLKS_PER_BIT cycles; this is enforced by a bit-period counter (0..CLKS_PER_BIT-1) and a bit index (0..DATA_W-1).
REQ-017 The bit-period counter SHALL reset to 0 on every bit boundary; the bit index SHALL advance only when the bit-period counter wraps in DATA, and DATA->PARITY SHALL occur when the index is DATA_W-1 and the counter wraps.
REQ-018 Frame length SHALL be (DATA_W+3)*CLKS_PER_BIT cycles from the first START cycle to the last STOP cycle; STOP->IDLE SHALL occur at the final counter wrap.
REQ-019 busy SHALL equal 1 in every state except IDLE.
REQ-020 din_valid and din changes SHALL be ignored while busy=1; the latched word SHALL NOT change mid-frame.
REQ-021 Back-to-back: with din_valid held high, the next accept SHALL occur in the first IDLE cycle, giving exactly one idle-high cycle between frames.
REQ-022 With CLKS_PER_BIT=1, every bit SHALL last exactly one cycle and no zero-length states are allowed.
REQ-023 par_out SHALL hold its value through IDLE until the next accept.

Reset
REQ-024 While rst=1, the block SHALL force state=IDLE, tx=1, busy=0, par_out=0, counters=0 and the shift register=0, independent of clk.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately, with tx returning to 1 asynchronously.
REQ-026 After rst deasserts, the first accept SHALL be possible at the first rising edge.

Verification
REQ-027 DATA_W=8, CLKS_PER_BIT=4, din=0xA5 accepted: tx sequence per 4-cycle bit is 0,1,0,1,0,0,1,0,1,0(parity),1; par_out=0; busy high for 44 cycles.
REQ-028 din=0x07 accepted: tx sequence is 0,1,1,1,0,0,0,0,0,1(parity),1; par_out=1.
REQ-029 din_valid held high with 0x01 then 0xFF: frames are separated by exactly 1 idle cycle; second parity=0; din_ready is high only in that single cycle.
REQ-030 Accept 0x3C, then at cycle 10 of DATA change din to 0xFF and pulse din_valid: transmitted bits still encode 0x3C, and parity=0.
REQ-031 Assert rst during DATA bit 3 for 1 cycle: tx=1, busy=0 and din_ready=1 immediately, and the next frame starts cleanly with a full-length START.
REQ-032 DATA_W=3, CLKS_PER_BIT=1, sweep din 0..7: par_out equals XOR of din for all 8 values and each frame is 6 cycles long.

Source files
------------

// File: rtl/parity_frame_tx.sv
// parity_frame_tx: serial frame transmitter (start, LSB-first data, even parity, stop).
// The line idles high. Outputs tx, busy and par_out are registered; din_ready is a
// direct decode of the IDLE state so a requester can present a word at any time.
module parity_frame_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx,
    output logic              busy,
    output logic              par_out
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic parity_even(input logic [DATA_W-1:0] word);
        return ^word;
    endfunction

    state_t              state_r, state_s;
    logic [CNT_W-1:0]    cnt_r, cnt_s;
    logic [IDX_W-1:0]    idx_r, idx_s;
    logic [DATA_W-1:0]   shreg_r, shreg_s;
    logic [DATA_W-1:0]   shifted_s;
    logic                par_r, par_s;
    logic                tx_r, tx_s;
    logic                busy_r, busy_s;
    logic                wrap_s;

    assign din_ready = (state_r == ST_IDLE);
    assign tx        = tx_r;
    assign busy      = busy_r;
    assign par_out   = par_r;

    // Next-state, counter and registered-output decode; tx/busy are computed for the
    // state being entered so they line up with that state's cycles.
    always_comb begin
        state_s   = state_r;
        cnt_s     = cnt_r;
        idx_s     = idx_r;
        shreg_s   = shreg_r;
        par_s     = par_r;
        tx_s      = tx_r;
        busy_s    = busy_r;
        wrap_s    = (cnt_r == CNT_MAX);
        shifted_s = shreg_r >> 1;
        case (state_r)
            ST_IDLE: begin
                tx_s   = 1'b1;
                busy_s = 1'b0;
                cnt_s  = '0;
                idx_s  = '0;
                if (din_valid) begin
                    state_s = ST_START;
                    shreg_s = din;
                    par_s   = parity_even(din);
                    tx_s    = 1'b0;
                    busy_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (wrap_s) begin
                    state_s = ST_DATA;
                    cnt_s   = '0;
                    idx_s   = '0;
                    tx_s    = shreg_r[0];
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (wrap_s) begin
                    cnt_s = '0;
                    if (idx_r == IDX_LAST) begin
                        state_s = ST_PARITY;
                        tx_s    = par_r;
                    end else begin
                        // Shift the next data bit into position 0.
                        idx_s   = idx_r + IDX_W'(1);
                        shreg_s = shifted_s;
                        tx_s    = shifted_s[0];
                    end
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                if (wrap_s) begin
                    state_s = ST_STOP;
                    cnt_s   = '0;
                    tx_s    = 1'b1;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            ST_STOP: begin
                if (wrap_s) begin
                    state_s = ST_IDLE;
                    cnt_s   = '0;
                    tx_s    = 1'b1;
                    busy_s  = 1'b0;
                end else begin
                    cnt_s = cnt_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = ST_IDLE;
                cnt_s   = '0;
                idx_s   = '0;
                tx_s    = 1'b1;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, counters, latched word and output registers; reset aborts any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
            cnt_r   <= '0;
            idx_r   <= '0;
            shreg_r <= '0;
            par_r   <= 1'b0;
            tx_r    <= 1'b1;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            idx_r   <= idx_s;
            shreg_r <= shreg_s;
            par_r   <= par_s;
            tx_r    <= tx_s;
            busy_r  <= busy_s;
        end
    end

endmodule

// File: tb/tb_parity_frame_tx.sv
// Testbench for parity_frame_tx: an 8-bit/4-clock instance and a 3-bit/1-clock
// instance, checked against a frame model built from the line-format rules.
module tb_parity_frame_tx;

    localparam int W   = 8;
    localparam int CPB = 4;
    localparam int NF  = (W + 3) * CPB;

    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   din;
    logic         din_valid;
    logic         din_ready, tx, busy, par_out;
    logic [2:0]   din3;
    logic         din_valid3;
    logic         din_ready3, tx3, busy3, par3;

    int checks = 0;
    int errors = 0;

    parity_frame_tx #(.DATA_W(W), .CLKS_PER_BIT(CPB)) u_dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
        .din_ready(din_ready), .tx(tx), .busy(busy), .par_out(par_out)
    );

    parity_frame_tx #(.DATA_W(3), .CLKS_PER_BIT(1)) u_dut3 (
        .clk(clk), .rst(rst), .din(din3), .din_valid(din_valid3),
        .din_ready(din_ready3), .tx(tx3), .busy(busy3), .par_out(par3)
    );

    always #5 clk = ~clk;

    // Count of ones, modulo 2: the even-parity bit.
    function automatic logic ref_parity(input int word, input int width);
        int ones = 0;
        for (int b = 0; b < width; b++) ones += (word >> b) & 1;
        return logic'(ones % 2);
    endfunction

    // Expected line level at cycle pos of a frame: start, data LSB first, parity, stop.
    function automatic logic ref_tx(input int word, input int width, input int cpb, input int pos);
        int slot = pos / cpb;
        if (slot == 0)          return 1'b0;
        else if (slot <= width) return logic'((word >> (slot - 1)) & 1);
        else if (slot == width + 1) return ref_parity(word, width);
        else                    return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word and take the accept edge; afterwards the DUT is in START cycle 0.
    task automatic accept(input logic [7:0] w);
        int budget = 0;
        while (din_ready !== 1'b1 && budget < 100) begin
            tick();
            budget++;
        end
        chk("ready_before_accept", 32'(din_ready), 32'd1);
        din       = w;
        din_valid = 1'b1;
        tick();
    endtask

    // Check a whole frame from START cycle 0 through the following IDLE cycle.
    task automatic frame_body(input logic [7:0] w, input bit disturb, input logic hold,
                              input logic [7:0] next_din);
        logic exp_par = ref_parity(int'(w), W);
        din       = next_din;
        din_valid = hold;
        for (int i = 0; i < NF; i++) begin
            chk($sformatf("tx_%02h_pos%0d", w, i), 32'(tx), 32'(ref_tx(int'(w), W, CPB, i)));
            chk("busy_in_frame", 32'(busy), 32'd1);
            chk("ready_in_frame", 32'(din_ready), 32'd0);
            chk("par_in_frame", 32'(par_out), 32'(exp_par));
            if (disturb && i == CPB + 10) begin
                din       = 8'hFF;
                din_valid = 1'b1;
            end
            if (disturb && i == CPB + 11) din_valid = 1'b0;
            tick();
        end
        chk("idle_tx", 32'(tx), 32'd1);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_ready", 32'(din_ready), 32'd1);
        chk("idle_par", 32'(par_out), 32'(exp_par));
    endtask

    initial begin
        logic [7:0] w;
        int gap;
        int len;
        rst        = 1'b1;
        din        = 8'h00;
        din_valid  = 1'b0;
        din3       = 3'd0;
        din_valid3 = 1'b0;
        #12;
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_par", 32'(par_out), 32'd0);
        chk("rst_ready", 32'(din_ready), 32'd1);
        rst = 1'b0;

        // 0xA5: parity 0, accepted on the first edge after reset release.
        accept(8'hA5);
        frame_body(8'hA5, 1'b0, 1'b0, 8'h00);
        chk("par_A5", 32'(par_out), 32'd0);

        // 0x07: parity 1.
        accept(8'h07);
        frame_body(8'h07, 1'b0, 1'b0, 8'h00);
        chk("par_07", 32'(par_out), 32'd1);

        // par_out holds through idle.
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("par_hold", 32'(par_out), 32'd1);
            chk("idle_hold_tx", 32'(tx), 32'd1);
        end

        // Back-to-back with din_valid held high: exactly one idle cycle.
        accept(8'h01);
        frame_body(8'h01, 1'b0, 1'b1, 8'hFF);
        tick();
        din_valid = 1'b0;
        frame_body(8'hFF, 1'b0, 1'b0, 8'h00);
        chk("par_FF", 32'(par_out), 32'd0);

        // Mid-frame din change and valid pulse are ignored.
        accept(8'h3C);
        frame_body(8'h3C, 1'b1, 1'b0, 8'h3C);
        chk("par_3C", 32'(par_out), 32'd0);

        // Random words with random idle gaps.
        for (int f = 0; f < 6; f++) begin
            w = 8'($urandom_range(0, 255));
            accept(w);
            frame_body(w, 1'b0, 1'b0, 8'($urandom));
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                tick();
                chk("gap_tx", 32'(tx), 32'd1);
                chk("gap_par", 32'(par_out), 32'(ref_parity(int'(w), W)));
            end
        end

        // Reset pulse during DATA bit 3 aborts the frame asynchronously.
        accept(8'h96);
        din_valid = 1'b0;
        for (int i = 0; i < 4 * CPB + 1; i++) tick();
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_tx", 32'(tx), 32'd1);
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_ready", 32'(din_ready), 32'd1);
        chk("async_rst_par", 32'(par_out), 32'd0);
        tick();
        rst = 1'b0;
        accept(8'h5A);
        frame_body(8'h5A, 1'b0, 1'b0, 8'h00);

        // Narrow instance: sweep every 3-bit word, 6-cycle frames.
        for (int v = 0; v < 8; v++) begin
            len = 0;
            while (din_ready3 !== 1'b1 && len < 20) begin
                tick();
                len++;
            end
            din3       = 3'(v);
            din_valid3 = 1'b1;
            tick();
            din_valid3 = 1'b0;
            len = 0;
            while (busy3 === 1'b1 && len < 20) begin
                chk($sformatf("tx3_v%0d_pos%0d", v, len), 32'(tx3), 32'(ref_tx(v, 3, 1, len)));
                tick();
                len++;
            end
            chk($sformatf("len3_v%0d", v), 32'(len), 32'd6);
            chk($sformatf("par3_v%0d", v), 32'(par3), 32'(ref_parity(v, 3)));
            chk("tx3_idle", 32'(tx3), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
